// File: rtl/tx_sequencer.sv
// tx_sequencer: paces I/Q sample delivery from the transmit byte FIFO to the
// IQ modulator. The FIFO holds interleaved bytes I, Q, I, Q, ... The block
// prefills the FIFO to a programmable level, then reads one I/Q pair per
// sample period and presents both halves together with a 1-cycle strobe.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   cfg_data         config byte from the SPI controller
//   cfg_wr_ctrl      write CTRL {clr_underrun, reprime, enable}
//   cfg_wr_div       write DIV   (period = DIV + MIN_PERIOD cycles)
//   cfg_wr_thresh    write THRESH (start level = max(THRESH*16, 2) bytes)
//   fifo_empty       FIFO empty flag
//   fifo_usedw       bytes currently held in the FIFO
//   fifo_q           FIFO read data, valid the cycle after fifo_rd
//   fifo_rd          FIFO read request
//   sample_i/q       I/Q sample to the modulator (IDLE_VAL when idle)
//   sample_valid     1-cycle pulse when sample_i/q update
//   tx_active        high in RUN
//   status           {4'b0, underrun, in_prefill, tx_active, enable}
module tx_sequencer #(
  parameter int         USEDW_W    = 12,
  parameter logic [7:0] IDLE_VAL   = 8'h00,
  parameter int         MIN_PERIOD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cfg_data,
  input  logic               cfg_wr_ctrl,
  input  logic               cfg_wr_div,
  input  logic               cfg_wr_thresh,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [7:0]         fifo_q,
  output logic               fifo_rd,
  output logic [7:0]         sample_i,
  output logic [7:0]         sample_q,
  output logic               sample_valid,
  output logic               tx_active,
  output logic [7:0]         status
);

  localparam int LW = (USEDW_W > 12) ? USEDW_W : 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFILL,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic          enable;
  logic          reprime;
  logic          underrun;
  logic [7:0]    div;
  logic [7:0]    thresh;
  logic [7:0]    cur_div;
  logic [8:0]    cnt;
  logic [8:0]    cnt_last;
  logic          pair_ok;
  logic [7:0]    i_hold;
  logic [7:0]    q_hold;
  logic [LW-1:0] level;
  logic          level_met;
  logic          pair_avail;
  logic          at_end;
  logic          underrun_set;
  logic          underrun_clr;

  // Level never drops below one full pair so RUN cannot start half a pair short.
  assign level      = (thresh == 8'd0) ? LW'(2) : LW'({thresh, 4'b0000});
  assign level_met  = LW'(fifo_usedw) >= level;
  assign pair_avail = (fifo_usedw >= USEDW_W'(2)) && !fifo_empty;

  // cur_div is reloaded at cnt==0, so the stale value seen in that one cycle
  // is harmless: the end compare is always >= MIN_PERIOD-1 > 0.
  assign cnt_last = 9'(cur_div) + 9'(MIN_PERIOD - 1);
  assign at_end   = (state == S_RUN) && (cnt == cnt_last);

  assign underrun_set = (state == S_RUN) && (cnt == 9'd0) && !pair_avail;
  assign underrun_clr = cfg_wr_ctrl && cfg_data[2];

  assign tx_active = (state == S_RUN);
  assign status    = {4'b0000, underrun, (state == S_PREFILL), (state == S_RUN), enable};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_PREFILL;
      end
      S_PREFILL: begin
        if (!enable)        state_nxt = S_IDLE;
        else if (level_met) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cnt == 9'd0 && pair_avail)             fifo_rd = 1'b1;
        if (cnt == 9'd1 && pair_ok && !fifo_empty) fifo_rd = 1'b1;
        // Disable is only honoured at period end so the FIFO stays pair-aligned.
        if (at_end) begin
          if (!enable)               state_nxt = S_IDLE;
          else if (!pair_ok && reprime) state_nxt = S_PREFILL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable   <= 1'b0;
      reprime  <= 1'b0;
      div      <= '0;
      thresh   <= '0;
      underrun <= 1'b0;
    end else begin
      if (cfg_wr_ctrl) begin
        enable  <= cfg_data[0];
        reprime <= cfg_data[1];
      end
      if (cfg_wr_div)    div    <= cfg_data;
      if (cfg_wr_thresh) thresh <= cfg_data;
      // Set wins over a simultaneous clear.
      if (underrun_set)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      cur_div      <= '0;
      pair_ok      <= 1'b0;
      i_hold       <= '0;
      q_hold       <= '0;
      sample_i     <= IDLE_VAL;
      sample_q     <= IDLE_VAL;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;

      if (state != S_RUN || at_end) cnt <= '0;
      else                          cnt <= cnt + 9'd1;

      if (state == S_RUN && cnt == 9'd0) begin
        cur_div <= div;
        pair_ok <= pair_avail;
      end
      if (state == S_RUN && cnt == 9'd1 && pair_ok) i_hold <= fifo_q;
      if (state == S_RUN && cnt == 9'd2 && pair_ok) q_hold <= fifo_q;

      // Going idle overrides a same-cycle pair update (only possible when
      // the period is exactly MIN_PERIOD).
      if (state_nxt == S_IDLE) begin
        sample_i <= IDLE_VAL;
        sample_q <= IDLE_VAL;
      end else if (state == S_RUN && cnt == 9'd3 && pair_ok) begin
        sample_i     <= i_hold;
        sample_q     <= q_hold;
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
module tb_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cfg_data = '0;
  logic        cfg_wr_ctrl = 1'b0;
  logic        cfg_wr_div = 1'b0;
  logic        cfg_wr_thresh = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [11:0] fifo_usedw = '0;
  logic [7:0]  fifo_q = '0;
  logic        fifo_rd;
  logic [7:0]  sample_i;
  logic [7:0]  sample_q;
  logic        sample_valid;
  logic        tx_active;
  logic [7:0]  status;

  tx_sequencer #(.USEDW_W(12), .IDLE_VAL(8'h00), .MIN_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_wr_ctrl(cfg_wr_ctrl),
    .cfg_wr_div(cfg_wr_div), .cfg_wr_thresh(cfg_wr_thresh),
    .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw), .fifo_q(fifo_q),
    .fifo_rd(fifo_rd), .sample_i(sample_i), .sample_q(sample_q),
    .sample_valid(sample_valid), .tx_active(tx_active), .status(status)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_count = 0;
  int valid_count = 0;
  int prev_rd_cyc = 0;
  int last_rd_cyc = 0;

  logic [7:0] fq[$];

  // Reference model: mode 0 idle, 1 prefill, 2 run; phase = cycles since period start.
  int         m_mode, m_phase, m_period;
  bit         m_good, m_en, m_rep, m_under, m_valid;
  int         m_div, m_thresh;
  logic [7:0] m_si, m_sq, m_pi, m_pq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void fifo_sigs();
    fifo_usedw = 12'(fq.size());
    fifo_empty = (fq.size() == 0);
  endfunction

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_sigs();
  endtask

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_period = 4; m_good = 0;
    m_en = 0; m_rep = 0; m_under = 0; m_valid = 0;
    m_div = 0; m_thresh = 0;
    m_si = 8'h00; m_sq = 8'h00; m_pi = 8'h00; m_pq = 8'h00;
  endfunction

  function automatic void model_step();
    int  nmode = m_mode;
    bit  nv = 0;
    bit  set_u = 0;
    int  lvl = (m_thresh * 16 > 2) ? m_thresh * 16 : 2;
    case (m_mode)
      0: if (m_en) nmode = 1;
      1: begin
        if (!m_en) nmode = 0;
        else if (fq.size() >= lvl) begin nmode = 2; m_phase = 0; end
      end
      default: begin
        if (m_phase == 0) begin
          m_period = m_div + 4;
          m_good = (fq.size() >= 2);
          if (!m_good) set_u = 1;
          else begin m_pi = fq[0]; m_pq = fq[1]; end
        end
        if (m_phase == 3 && m_good) begin m_si = m_pi; m_sq = m_pq; nv = 1; end
        if (m_phase == m_period - 1) begin
          m_phase = 0;
          if (!m_en) nmode = 0;
          else if (!m_good && m_rep) nmode = 1;
        end else m_phase++;
      end
    endcase
    if (nmode == 0) begin m_si = 8'h00; m_sq = 8'h00; nv = 0; end
    m_valid = nv;
    m_mode = nmode;
    if (cfg_wr_ctrl) begin m_en = cfg_data[0]; m_rep = cfg_data[1]; end
    if (set_u) m_under = 1;
    else if (cfg_wr_ctrl && cfg_data[2]) m_under = 0;
    if (cfg_wr_div) m_div = cfg_data;
    if (cfg_wr_thresh) m_thresh = cfg_data;
  endfunction

  task automatic tick();
    bit rd_now;
    bit exp_rd;
    @(negedge clk);
    exp_rd = (m_mode == 2) && ((m_phase == 0 && fq.size() >= 2) || (m_phase == 1 && m_good));
    check("fifo_rd", fifo_rd, exp_rd);
    check("sample_valid", sample_valid, m_valid);
    check("sample_i", sample_i, m_si);
    check("sample_q", sample_q, m_sq);
    check("tx_active", tx_active, m_mode == 2);
    check("status", status, {4'b0, m_under, m_mode == 1, m_mode == 2, m_en});
    rd_now = fifo_rd;
    if (sample_valid) valid_count++;
    model_step();
    @(posedge clk);
    #1;
    if (rd_now) begin
      rd_count++;
      prev_rd_cyc = last_rd_cyc;
      last_rd_cyc = cyc;
      if (fq.size() != 0) fifo_q = fq.pop_front();
    end
    cfg_wr_ctrl = 0; cfg_wr_div = 0; cfg_wr_thresh = 0;
    fifo_sigs();
    cyc++;
  endtask

  task automatic cfg_write(input int which, input logic [7:0] d);
    cfg_data = d;
    cfg_wr_ctrl = (which == 0);
    cfg_wr_div = (which == 1);
    cfg_wr_thresh = (which == 2);
    tick();
  endtask

  task automatic do_reset();
    rst = 1;
    fq.delete();
    fifo_q = '0;
    cfg_wr_ctrl = 0; cfg_wr_div = 0; cfg_wr_thresh = 0;
    fifo_sigs();
    model_reset();
    @(negedge clk);
    check("rst_status", status, 8'h00);
    check("rst_rd", fifo_rd, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_si", sample_i, 8'h00);
    check("rst_sq", sample_q, 8'h00);
    check("rst_active", tx_active, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  function automatic bit cond_met(input int sel);
    case (sel)
      0: return sample_valid;
      1: return fifo_rd;
      2: return status[3];
      3: return status == 8'h0D;
      4: return !tx_active;
      default: return tx_active;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input int budget);
    int n = 0;
    while (!cond_met(sel) && n < budget) begin tick(); n++; end
    check(tag, cond_met(sel), 1);
  endtask

  initial begin
    int t0;
    int base_rd, base_v;
    model_reset();
    do_reset();

    // Prefill to 32 bytes, first pairs at DIV=0
    cfg_write(2, 8'd2);
    cfg_write(1, 8'd0);
    cfg_write(0, 8'h01);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int k = 4; k < 31; k++) push(8'(k * 7 + 3));
    repeat (3) tick();
    check("prefill_status", status, 8'h05);
    check("prefill_rd", fifo_rd, 0);
    push(8'hA5);
    tick();
    check("run_after_32", tx_active, 1);
    wait_until("first_rd", 1, 10);
    t0 = cyc;
    wait_until("first_valid", 0, 20);
    check("first_latency", cyc - t0, 4);
    check("pair1_i", sample_i, 8'h11);
    check("pair1_q", sample_q, 8'h22);
    tick();
    wait_until("second_valid", 0, 20);
    check("pair2_i", sample_i, 8'h33);
    check("pair2_q", sample_q, 8'h44);

    // Period 10
    cfg_write(1, 8'd6);
    for (int k = 0; k < 64; k++) push(8'($urandom));
    for (int k = 0; k < 3; k++) begin tick(); wait_until("div_settle", 0, 40); end
    t0 = cyc;
    base_rd = rd_count;
    tick();
    wait_until("div6_valid", 0, 40);
    check("div6_spacing", cyc - t0, 10);
    check("div6_rds", rd_count - base_rd, 2);
    check("div6_rd_consec", last_rd_cyc - prev_rd_cyc, 1);

    // Starvation, reprime off
    cfg_write(0, 8'h05);
    check("clr_before_starve", status[3], 0);
    wait_until("underrun_seen", 2, 1500);
    repeat (25) tick();
    check("starve_stays_run", tx_active, 1);
    for (int k = 0; k < 20; k++) push(8'($urandom));
    wait_until("resume_valid", 0, 40);
    cfg_write(0, 8'h05);
    check("clr_underrun", status[3], 0);

    // Starvation, reprime on
    cfg_write(0, 8'h03);
    wait_until("reprime_prefill", 3, 1500);
    for (int k = 0; k < 30; k++) push(8'($urandom));
    repeat (5) tick();
    check("reprime_below_level", status, 8'h0D);
    push(8'h5A); push(8'hC3);
    tick();
    check("reprime_run", tx_active, 1);

    // Disable at cnt==1, period 6
    cfg_write(1, 8'd2);
    cfg_write(0, 8'h01);
    for (int k = 0; k < 40; k++) push(8'($urandom));
    for (int k = 0; k < 2; k++) begin tick(); wait_until("dis_settle", 0, 40); end
    wait_until("dis_rd", 1, 20);
    base_rd = rd_count;
    base_v = valid_count;
    tick();
    cfg_write(0, 8'h00);
    wait_until("dis_idle", 4, 20);
    check("dis_rds", rd_count - base_rd, 2);
    check("dis_pair_done", valid_count - base_v, 1);
    check("dis_si", sample_i, 8'h00);
    check("dis_sq", sample_q, 8'h00);
    check("dis_even", fifo_usedw[0], 0);
    repeat (5) tick();

    // Randomized traffic
    cfg_write(2, 8'(3'($urandom_range(0, 3))));
    cfg_write(0, 8'h01);
    for (int n = 0; n < 3000; n++) begin
      if (fq.size() < 150 && $urandom_range(0, 99) < 30) push(8'($urandom));
      if ($urandom_range(0, 199) == 0)
        cfg_write(0, {5'b0, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0)});
      else if ($urandom_range(0, 299) == 0)
        cfg_write(1, 8'($urandom_range(0, 12)));
      else if ($urandom_range(0, 499) == 0)
        cfg_write(2, 8'($urandom_range(0, 3)));
      else if ($urandom_range(0, 149) == 0)
        cfg_write(0, 8'h01);
      else
        tick();
    end

    // Async reset mid-period
    cfg_write(0, 8'h01);
    cfg_write(2, 8'd0);
    for (int k = 0; k < 8; k++) push(8'($urandom));
    wait_until("pre_reset_run", 5, 20);
    wait_until("pre_reset_rd", 1, 20);
    tick();
    #2;
    do_reset();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_sequencer.md
Name: tx_sequencer

Overview:
- Paces sample delivery from the transmit byte FIFO to the IQ modulator.
- FIFO holds interleaved bytes in the order I, Q, I, Q, ...
- The block prefills the FIFO to a programmable threshold, then reads one I/Q pair per programmable sample period and presents both halves simultaneously.
- Detects underrun and optionally re-primes. Configured by the SPI controller through byte-wide register strobes.

Parameters:
- USEDW_W, 12, width of FIFO used-words count.
- IDLE_VAL, 8'h00, value driven on sample_i/sample_q when not delivering data.
- MIN_PERIOD, 4, minimum sample period in clk cycles (fixed by the read pipeline; not to be set below 4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_data  in  8  config byte from controller.
- cfg_wr_ctrl  in  1  write cfg_data to CTRL (1-cycle strobe).
- cfg_wr_div  in  1  write cfg_data to DIV.
- cfg_wr_thresh  in  1  write cfg_data to THRESH.
- fifo_empty  in  1  FIFO empty.
- fifo_usedw  in  USEDW_W  bytes currently in FIFO.
- fifo_q  in  8  FIFO read data, valid the cycle after fifo_rd (non-show-ahead).
- fifo_rd  out  1  FIFO read request.
- sample_i  out  8  I sample to modulator.
- sample_q  out  8  Q sample to modulator.
- sample_valid  out  1  1-cycle pulse when sample_i/q update.
- tx_active  out  1  high in RUN.
- status  out  8  {4'b0, underrun, in_prefill, tx_active, enable}.

Behaviour:
- Reset: all registers 0; state IDLE.
  - Outputs: fifo_rd=0, sample_i=sample_q=IDLE_VAL, sample_valid=0, tx_active=0, status=0.
- Registers:
  - CTRL: bit0 enable, bit1 reprime (on underrun return to PREFILL), bit2 clr_underrun (write-one, self-clearing, not stored).
  - DIV: period = DIV + MIN_PERIOD cycles, range 4..259.
  - THRESH: start level = THRESH*16 bytes; level is max(THRESH*16, 2).
  - A write takes effect the next cycle. A DIV change applies at the next period start.
- States:
  - IDLE: outputs IDLE_VAL. enable=1 -> PREFILL.
  - PREFILL: in_prefill=1. enable=0 -> IDLE. fifo_usedw >= level -> RUN with period counter cnt=0.
  - RUN: cnt counts 0..period-1 and wraps.
    - cnt==0: if fifo_usedw>=2 and !fifo_empty, assert fifo_rd (I byte); otherwise underrun event, no reads this period.
    - cnt==1: fifo_rd (Q byte); latch fifo_q into i_hold.
    - cnt==2: latch fifo_q into q_hold.
    - cnt==3: sample_i<=i_hold, sample_q<=q_hold, sample_valid=1.
  - Each pair therefore appears 4 cycles after its I read. Exactly 2 reads per good period.
- Underrun event:
  - Set sticky underrun. Skip the cnt==1 read. sample_i/q hold their last values. No sample_valid pulse.
  - If reprime=1, go to PREFILL at period end; otherwise stay in RUN and retry at the next cnt==0.
- Disable while in RUN:
  - Takes effect at cnt==period-1 (period end), so I/Q pair alignment in the FIFO is never broken.
  - Then IDLE; sample_i/q return to IDLE_VAL in the IDLE cycle.
- Underrun flag priority: a clr_underrun write in the same cycle as an underrun event leaves underrun=1 (set wins).
- fifo_rd is never asserted outside RUN cnt 0/1, and never when fifo_empty=1.
- Asynchronous reset mid-period: abandons any pending pair immediately. The FIFO is cleared by the same reset, so no realignment is needed.

Test Plan:
- Reset; then THRESH=2 (32 B), DIV=0, enable=1. Push 31 bytes -> stays PREFILL, fifo_rd=0. Push 32nd byte -> RUN next cycle.
- Push bytes 0x11,0x22,0x33,0x44, DIV=0 -> sample_valid every 4 cycles. First pair I=0x11/Q=0x22 appears 4 cycles after the first fifo_rd; then 0x33/0x44.
- DIV=6 -> sample_valid spacing exactly 10 cycles. Exactly 2 fifo_rd per period, on consecutive cycles.
- Starve the FIFO in RUN with reprime=0 -> underrun=1, outputs hold the last pair, no sample_valid. Refill -> resumes next period. clr_underrun -> status bit3 = 0.
- Same starvation with reprime=1 -> returns to PREFILL (status=0x0D); resumes only after the threshold is met again.
- Write enable=0 at cnt==1 -> the Q read still occurs and the pair completes. IDLE after period end; sample_i/q = 0x00; FIFO usedw is even.
